softmax_max_sub: RTL and testbench

Vector max-subtract stage at the front of the softmax datapath. It buffers one VEC_LEN-element vector, finds its maximum, then streams each element minus that maximum so that every value going into the exponent stage is ≤ 0. It also pulses `max_set` with the vector maximum on `max_out`, so the following load-enable register can capture it for later normalisation.

---
 rtl/softmax_max_sub.sv | 113 +++++++++++
 tb/tb_softmax_max_sub.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/softmax_max_sub.sv
// softmax_max_sub: buffers one vector, tracks its signed maximum, then streams
// each element minus that maximum (saturated) so every downstream value is <= 0.
// max_set pulses with the final maximum on max_out in the first output cycle.
module softmax_max_sub #(
  parameter int DATA_WIDTH = 16,
  parameter int VEC_LEN    = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         soft_clr,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_last,
  output logic signed [DATA_WIDTH-1:0] max_out,
  output logic                         max_set
);

  localparam int IW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(VEC_LEN - 1);
  localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  typedef enum logic {LOAD = 1'b0, DRAIN = 1'b1} state_t;

  state_t                         r_state, w_state_nxt;
  logic [IW-1:0]                  r_wr_cnt, r_rd_cnt;
  logic signed [DATA_WIDTH-1:0]   r_max;
  logic                           r_max_set;
  logic signed [DATA_WIDTH-1:0]   r_buf [VEC_LEN];
  logic                           w_in_acc, w_out_acc, w_in_last;
  logic signed [DATA_WIDTH-1:0]   w_rd_elem;
  logic signed [DATA_WIDTH:0]     w_diff;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= LOAD;
    else        r_state <= w_state_nxt;
  end

  // Next state and handshakes; a handshake coinciding with soft_clr is dropped
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    w_in_acc    = 1'b0;
    w_out_acc   = 1'b0;
    unique case (r_state)
      LOAD: begin
        in_ready = 1'b1;
        w_in_acc = in_valid && !soft_clr;
        if (w_in_acc && (r_wr_cnt == LAST_IDX)) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        w_out_acc = out_ready && !soft_clr;
        if (w_out_acc && (r_rd_cnt == LAST_IDX)) w_state_nxt = LOAD;
      end
      default: w_state_nxt = LOAD;
    endcase
    if (soft_clr) w_state_nxt = LOAD;
  end

  assign w_in_last = w_in_acc && (r_wr_cnt == LAST_IDX);

  // Write/read counters, wrapping at the vector end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else if (soft_clr) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else begin
      if (w_in_acc)  r_wr_cnt <= (r_wr_cnt == LAST_IDX) ? '0 : r_wr_cnt + 1'b1;
      if (w_out_acc) r_rd_cnt <= (r_rd_cnt == LAST_IDX) ? '0 : r_rd_cnt + 1'b1;
    end
  end

  // Running max: first element loads, later ones only if strictly greater (ties keep r_max quiet)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_max     <= '0;
      r_max_set <= 1'b0;
    end else begin
      r_max_set <= w_in_last;
      if (w_in_acc && ((r_wr_cnt == '0) || (in_data > r_max))) r_max <= in_data;
    end
  end

  // Element buffer; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (w_in_acc) r_buf[r_wr_cnt] <= in_data;
  end

  // Difference in DATA_WIDTH+1 bits, clamped back to DATA_WIDTH
  always_comb begin
    w_rd_elem = r_buf[r_rd_cnt];
    w_diff    = {w_rd_elem[DATA_WIDTH-1], w_rd_elem} - {r_max[DATA_WIDTH-1], r_max};
    if (w_diff[DATA_WIDTH] != w_diff[DATA_WIDTH-1])
      out_data = w_diff[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
    else
      out_data = w_diff[DATA_WIDTH-1:0];
  end

  assign out_last = (r_state == DRAIN) && (r_rd_cnt == LAST_IDX);
  assign max_out  = r_max;
  assign max_set  = r_max_set;

endmodule

// File: tb/tb_softmax_max_sub.sv
// Bench for softmax_max_sub (VEC_LEN=4, 16-bit): directed plan plus random vectors
// checked against a plain-arithmetic model of max and saturated subtraction.
module tb_softmax_max_sub;
  localparam int W = 16;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic soft_clr = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic signed [W-1:0] in_data = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic signed [W-1:0] out_data;
  logic out_last;
  logic signed [W-1:0] max_out;
  logic max_set;

  int checks = 0;
  int errors = 0;
  int last_max = 0;

  always #5 clk = ~clk;

  softmax_max_sub #(.DATA_WIDTH(W), .VEC_LEN(N)) dut (
    .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .max_out(max_out), .max_set(max_set)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int vmax(input int v[N]);
    int m = v[0];
    for (int i = 1; i < N; i++) if (v[i] > m) m = v[i];
    return m;
  endfunction

  function automatic int satsub(input int a, input int m);
    int d = a - m;
    if (d < -32768) d = -32768;
    return d;
  endfunction

  // Feed one vector; gaps[i] idle cycles before element i. Ends at the negedge after the last handshake.
  task automatic send_vec(input int v[N], input int gaps[N]);
    int run = last_max;
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b0;
      repeat (gaps[i]) begin
        @(negedge clk);
        chk("max_hold_bubble", max_out, run);
        chk("no_max_set_bubble", max_set, 0);
      end
      in_valid = 1'b1;
      in_data  = W'(v[i]);
      chk("in_ready_load", in_ready, 1);
      chk("out_valid_load", out_valid, 0);
      chk("max_set_load", max_set, 0);
      chk("max_out_load", max_out, run);
      @(negedge clk);
      if (i == 0 || v[i] > run) run = v[i];
    end
    in_valid = 1'b0;
  endtask

  // Check the drain of vector v, optionally stalling stall_n cycles on element stall_idx.
  task automatic drain_chk(input int v[N], input int stall_idx, input int stall_n);
    int mx = vmax(v);
    int e;
    chk("max_set_pulse", max_set, 1);
    chk("max_out_final", max_out, mx);
    for (int i = 0; i < N; i++) begin
      e = satsub(v[i], mx);
      chk("out_valid", out_valid, 1);
      chk("out_data", out_data, e);
      chk("out_last", out_last, (i == N - 1) ? 1 : 0);
      chk("in_ready_drain", in_ready, 0);
      if (i > 0) chk("max_set_once", max_set, 0);
      if (i == stall_idx) begin
        out_ready = 1'b0;
        repeat (stall_n) begin
          @(negedge clk);
          chk("stall_valid", out_valid, 1);
          chk("stall_data", out_data, e);
          chk("stall_last", out_last, (i == N - 1) ? 1 : 0);
          chk("stall_in_ready", in_ready, 0);
          chk("stall_max_set", max_set, 0);
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    chk("in_ready_back", in_ready, 1);
    chk("out_valid_done", out_valid, 0);
    chk("max_out_held", max_out, mx);
    last_max = mx;
  endtask

  initial begin
    int v[N];
    int g[N];
    int z[N];
    z = '{0, 0, 0, 0};

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_max_out", max_out, 0);
    chk("rst_max_set", max_set, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic vector
    v = '{3, -2, 7, 7};
    send_vec(v, z);
    drain_chk(v, N, 0);

    // Saturation
    v = '{32767, -32768, 0, 1};
    send_vec(v, z);
    drain_chk(v, N, 0);

    // Backpressure on element 2
    v = '{100, -300, 250, 5};
    send_vec(v, z);
    drain_chk(v, 2, 5);

    // Bubbles and all-negative vector
    v = '{-5, -1, -9, -1};
    g = '{0, 3, 0, 2};
    send_vec(v, g);
    drain_chk(v, N, 0);

    // soft_clr mid-LOAD: two accepted elements, third handshake dropped with the clear
    in_valid = 1'b1; in_data = 16'sd50; @(negedge clk);
    in_data = 16'sd60; @(negedge clk);
    in_data = 16'sd100; soft_clr = 1'b1; @(negedge clk);
    soft_clr = 1'b0; in_valid = 1'b0;
    chk("sclr_in_ready", in_ready, 1);
    chk("sclr_out_valid", out_valid, 0);
    chk("sclr_max_set", max_set, 0);
    chk("sclr_max_kept", max_out, 60);
    last_max = 60;
    v = '{1, 2, 3, 4};
    send_vec(v, z);
    drain_chk(v, N, 0);

    // rst_n mid-DRAIN after one output
    v = '{-20, 40, 10, -7};
    send_vec(v, z);
    chk("pre_rst_max_set", max_set, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_max_out", max_out, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_last", out_last, 0);
    @(negedge clk);
    rst_n = 1'b1;
    last_max = 0;
    v = '{9, -9, 12, 11};
    send_vec(v, z);
    drain_chk(v, N, 0);

    // Random vectors with random bubbles and stalls
    for (int k = 0; k < 25; k++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 5))
          0: v[i] = 32767;
          1: v[i] = -32768;
          2: v[i] = int'($urandom_range(0, 20)) - 10;
          default: v[i] = int'($urandom_range(0, 65535)) - 32768;
        endcase
        g[i] = $urandom_range(0, 2);
      end
      send_vec(v, g);
      drain_chk(v, $urandom_range(0, N), $urandom_range(1, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
